// File: rtl/fetch_ref_luma_ld_pkg.sv
// Shared constants and types for the reference-luma window loader.
package fetch_ref_luma_ld_pkg;

    localparam int PIC_X_WIDTH = 8;
    localparam int PIC_Y_WIDTH = 8;
    localparam int PIXEL_WIDTH = 8;

    localparam int LCU_SIZE    = 64;
    localparam int SR_MARGIN   = 16;
    localparam int WIN_W       = 96;
    localparam int BEAT_W      = 32;
    localparam int ROW_AW      = 7;

    localparam int RD_X_W      = PIC_X_WIDTH + 6;
    localparam int RD_Y_W      = PIC_Y_WIDTH + 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RECV  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PAD_NONE  = 2'd0,
        PAD_LEFT  = 2'd1,
        PAD_RIGHT = 2'd2
    } pad_mode_t;

endpackage

// File: rtl/fetch_ref_luma_pad.sv
// Combinational 96-pixel edge-replication shifter: left pad replicates
// pixel 0 ahead of the row, right pad replicates pixel 95 after it.
module fetch_ref_luma_pad
    import fetch_ref_luma_ld_pkg::*;
(
    input  pad_mode_t                      mode,
    input  logic [WIN_W*PIXEL_WIDTH-1:0]   row_in,
    output logic [WIN_W*PIXEL_WIDTH-1:0]   row_out
);

    // Source pixel index feeding output pixel i for the selected mode.
    function automatic int pad_src(input pad_mode_t m, input int i);
        int src;
        src = i;
        case (m)
            PAD_LEFT:  src = (i < SR_MARGIN) ? 0 : i - SR_MARGIN;
            PAD_RIGHT: src = (i >= WIN_W - SR_MARGIN) ? WIN_W - 1 : i + SR_MARGIN;
            default:   src = i;
        endcase
        return src;
    endfunction

    // Gather every output pixel from its source position (pixel 0 in MSBs).
    always_comb begin
        row_out = '0;
        for (int i = 0; i < WIN_W; i++) begin
            row_out[(WIN_W-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH] =
                row_in[(WIN_W-1-pad_src(mode, i))*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end

endmodule

// File: rtl/fetch_ref_luma_ld.sv
// Reference-luma window loader: requests 80 rows of 96 pixels for one LCU,
// assembles each row from 32-pixel beats, pads picture edges and writes the
// rows into the ref-luma buffer, then pulses done.
module fetch_ref_luma_ld
    import fetch_ref_luma_ld_pkg::*;
#(
    parameter int ROWS  = 80,
    parameter int BEATS = 3
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start_i,
    input  logic [PIC_X_WIDTH-1:0]           cur_x_i,
    input  logic [PIC_Y_WIDTH-1:0]           cur_y_i,
    input  logic [PIC_X_WIDTH-1:0]           sysif_total_x_i,
    output logic                             busy_o,
    output logic                             ext_rd_req_o,
    input  logic                             ext_rd_ack_i,
    output logic [RD_X_W-1:0]                ext_rd_x_o,
    output logic [RD_Y_W-1:0]                ext_rd_y_o,
    input  logic                             ext_rd_valid_i,
    input  logic [BEAT_W*PIXEL_WIDTH-1:0]    ext_rd_data_i,
    output logic                             ext_load_valid_o,
    output logic [ROW_AW-1:0]                ext_load_addr_o,
    output logic [WIN_W*PIXEL_WIDTH-1:0]     ext_load_data_o,
    output logic                             ext_load_done_o
);

    localparam int BEAT_CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BITS = BEAT_W * PIXEL_WIDTH;

    state_t                          state, state_nxt;
    logic [ROW_AW-1:0]               row;
    logic [BEAT_CW-1:0]              beat;
    logic [WIN_W*PIXEL_WIDTH-1:0]    asm_row;
    logic [PIC_X_WIDTH-1:0]          cur_x_q;
    logic [PIC_Y_WIDTH-1:0]          cur_y_q;
    logic                            right_q;
    pad_mode_t                       pad_mode;

    wire last_row  = (row == ROW_AW'(ROWS - 1));
    wire last_beat = (beat == BEAT_CW'(BEATS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt        = state;
        busy_o           = 1'b1;
        ext_rd_req_o     = 1'b0;
        ext_load_valid_o = 1'b0;
        ext_load_done_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                ext_rd_req_o = 1'b1;
                if (ext_rd_ack_i) state_nxt = ST_RECV;
            end
            ST_RECV: begin
                if (ext_rd_valid_i && last_beat) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                ext_load_valid_o = 1'b1;
                state_nxt        = last_row ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                ext_load_done_o = 1'b1;
                state_nxt       = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // LCU latch, row/beat counters and beat assembly.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_x_q <= '0;
            cur_y_q <= '0;
            right_q <= 1'b0;
            row     <= '0;
            beat    <= '0;
            asm_row <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        cur_x_q <= cur_x_i;
                        cur_y_q <= cur_y_i;
                        right_q <= (cur_x_i != '0) && (cur_x_i == sysif_total_x_i);
                        row     <= '0;
                    end
                end
                ST_REQ: begin
                    if (ext_rd_ack_i) beat <= '0;
                end
                ST_RECV: begin
                    if (ext_rd_valid_i) begin
                        asm_row[(BEATS-1-int'(beat))*BEAT_BITS +: BEAT_BITS] <= ext_rd_data_i;
                        beat <= beat + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!last_row) row <= row + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Left edge wins when the picture is a single LCU wide.
    always_comb begin
        if (cur_x_q == '0) pad_mode = PAD_LEFT;
        else if (right_q)  pad_mode = PAD_RIGHT;
        else               pad_mode = PAD_NONE;
    end

    // Request coordinates: window starts one margin above/left of the LCU,
    // shifted a further margin left at the right picture edge.
    always_comb begin
        case (pad_mode)
            PAD_LEFT:  ext_rd_x_o = '0;
            PAD_RIGHT: ext_rd_x_o = {cur_x_q, 6'b0} - RD_X_W'(2 * SR_MARGIN);
            default:   ext_rd_x_o = {cur_x_q, 6'b0} - RD_X_W'(SR_MARGIN);
        endcase
        if (cur_y_q == '0) ext_rd_y_o = RD_Y_W'(row);
        else               ext_rd_y_o = {cur_y_q, 6'b0} - RD_Y_W'(SR_MARGIN) + RD_Y_W'(row);
    end

    assign ext_load_addr_o = row;

    fetch_ref_luma_pad u_pad (
        .mode    (pad_mode),
        .row_in  (asm_row),
        .row_out (ext_load_data_o)
    );

endmodule

// File: tb/tb_fetch_ref_luma_ld.sv
// Bench for fetch_ref_luma_ld: memory responder, row scoreboard, vector table,
// randomized windows and hand-written abort/restart sequences.
module tb_fetch_ref_luma_ld;
    import fetch_ref_luma_ld_pkg::*;

    localparam int ROWS      = 80;
    localparam int BEATS     = 3;
    localparam int PW        = PIXEL_WIDTH;
    localparam int ROW_BITS  = WIN_W * PW;
    localparam int BEAT_BITS = BEAT_W * PW;

    logic                   clk;
    logic                   rstn;
    logic                   start;
    logic [PIC_X_WIDTH-1:0] cur_x, total_x;
    logic [PIC_Y_WIDTH-1:0] cur_y;
    logic                   busy, req, ack, rd_valid, ld_valid, done;
    logic [RD_X_W-1:0]      rd_x;
    logic [RD_Y_W-1:0]      rd_y;
    logic [BEAT_BITS-1:0]   rd_data;
    logic [ROW_AW-1:0]      ld_addr;
    logic [ROW_BITS-1:0]    ld_data;

    fetch_ref_luma_ld #(.ROWS(ROWS), .BEATS(BEATS)) dut (
        .clk(clk), .rstn(rstn), .start_i(start), .cur_x_i(cur_x), .cur_y_i(cur_y),
        .sysif_total_x_i(total_x), .busy_o(busy), .ext_rd_req_o(req),
        .ext_rd_ack_i(ack), .ext_rd_x_o(rd_x), .ext_rd_y_o(rd_y),
        .ext_rd_valid_i(rd_valid), .ext_rd_data_i(rd_data),
        .ext_load_valid_o(ld_valid), .ext_load_addr_o(ld_addr),
        .ext_load_data_o(ld_data), .ext_load_done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cx, cy, tx;
        int ack_dly, gap;
        bit spur, restart, a5;
        int ex, ey, ebusy;
    } vec_t;

    int  total = 0, bad = 0;
    int  k_ack_dly = 0, k_gap = 0;
    bit  k_spur = 0, k_a5 = 0;
    int  exp_x = 0, exp_ybase = 0, exp_mode = 0;
    int  exp_row = 0, busy_cnt = 0, last_wr = 0, cyc = 0, done_cnt = 0;
    bit  done_seen = 0, chk_en = 0;
    logic [7:0] seed;

    task automatic chk(input string name, input logic [ROW_BITS-1:0] act,
                       input logic [ROW_BITS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // External memory contents: a scrambled function of pixel coordinates.
    function automatic logic [7:0] mem_pix(input int y, input int x);
        if (k_a5 && x == 0) return 8'hA5;
        return 8'((y * 131 + x * 37 + (y ^ x) * 7)) ^ seed;
    endfunction

    // Row the buffer should receive for window row at picture line y.
    function automatic logic [ROW_BITS-1:0] model_row(input int y);
        logic [7:0] recv [WIN_W];
        logic [ROW_BITS-1:0] r;
        logic [7:0] p;
        for (int i = 0; i < WIN_W; i++) recv[i] = mem_pix(y, exp_x + i);
        r = '0;
        for (int i = 0; i < WIN_W; i++) begin
            if (exp_mode == 1) begin
                if (i < 16) p = recv[0]; else p = recv[i-16];
            end else if (exp_mode == 2) begin
                if (i >= 80) p = recv[95]; else p = recv[i+16];
            end else p = recv[i];
            r[(WIN_W-1-i)*PW +: PW] = p;
        end
        return r;
    endfunction

    // Memory responder: answers each request after k_ack_dly cycles, then
    // returns BEATS beats separated by k_gap idle cycles.
    initial begin
        logic [RD_X_W-1:0] x0;
        logic [RD_Y_W-1:0] y0;
        ack = 0; rd_valid = 0; rd_data = '0;
        forever begin
            @(negedge clk);
            if (!(req === 1'b1) || !rstn) continue;
            x0 = rd_x; y0 = rd_y;
            for (int d = 0; d < k_ack_dly; d++) begin
                if (k_spur) begin
                    rd_valid = 1;
                    rd_data = {$urandom, $urandom, $urandom, $urandom,
                               $urandom, $urandom, $urandom, $urandom};
                end
                @(negedge clk);
                rd_valid = 0;
                if (chk_en) begin
                    chk("req_held", req, 1);
                    chk("req_x_stable", rd_x, x0);
                    chk("req_y_stable", rd_y, y0);
                end
            end
            if (chk_en) begin
                chk("rd_x", rd_x, exp_x);
                chk("rd_y", rd_y, exp_ybase + exp_row);
            end
            x0 = rd_x; y0 = rd_y;
            ack = 1;
            @(negedge clk);
            ack = 0;
            for (int b = 0; b < BEATS; b++) begin
                for (int g = 0; g < k_gap; g++) @(negedge clk);
                for (int j = 0; j < BEAT_W; j++)
                    rd_data[(BEAT_W-1-j)*PW +: PW] = mem_pix(int'(y0), int'(x0) + 32*b + j);
                rd_valid = 1;
                @(negedge clk);
                rd_valid = 0;
            end
        end
    end

    // Write scoreboard: rows in address order with padded contents, done
    // exactly one cycle after the last write.
    always @(negedge clk) begin
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (chk_en) begin
            if (busy === 1'b1) busy_cnt++;
            if (ld_valid === 1'b1) begin
                chk("ld_addr", ld_addr, exp_row);
                chk("ld_data", ld_data, model_row(exp_ybase + exp_row));
                last_wr = cyc;
                exp_row++;
            end
            if (done === 1'b1) begin
                chk("done_after_last_write", cyc, last_wr + 1);
                chk("rows_before_done", exp_row, ROWS);
                done_seen = 1;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req"}, req, 0);
        chk({tag, "_rd_x"}, rd_x, 0);
        chk({tag, "_rd_y"}, rd_y, 0);
        chk({tag, "_ld_valid"}, ld_valid, 0);
        chk({tag, "_ld_addr"}, ld_addr, 0);
        chk({tag, "_ld_data"}, ld_data, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic begin_window(input vec_t v);
        k_ack_dly = v.ack_dly; k_gap = v.gap; k_spur = v.spur; k_a5 = v.a5;
        exp_x = v.ex; exp_ybase = v.ey;
        exp_mode = (v.cx == 0) ? 1 : (v.cx == v.tx) ? 2 : 0;
        @(negedge clk); #1;
        exp_row = 0; busy_cnt = 0; done_seen = 0; last_wr = -10; chk_en = 1;
        cur_x = PIC_X_WIDTH'(v.cx); cur_y = PIC_Y_WIDTH'(v.cy);
        total_x = PIC_X_WIDTH'(v.tx); start = 1;
        @(negedge clk); #1;
        start = 0;
    endtask

    task automatic run_window(input vec_t v);
        begin_window(v);
        for (int c = 0; c < 5000 && !done_seen; c++) begin
            @(negedge clk); #1;
            start = 0;
            if (v.restart && c == 150) begin
                start = 1;
                cur_x = cur_x + 1'b1;
                cur_y = cur_y + 2'd2;
            end
        end
        chk("done_seen", done_seen, 1);
        if (v.ebusy != 0) chk("busy_cycles", busy_cnt, v.ebusy);
        chk("rows_written", exp_row, ROWS);
        @(negedge clk); #1;
        chk("idle_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk_en = 0;
    endtask

    vec_t vecs [6];

    initial begin
        vec_t v;
        int   d0, mode;
        seed = 8'($urandom);
        rstn = 0; start = 0; cur_x = '0; cur_y = '0; total_x = '0;

        //            cx cy tx dly gap spur rst a5   ex  ey  busy
        vecs[0] = '{3, 2, 9, 0, 0, 0, 0, 0, 176, 112, 401};
        vecs[1] = '{0, 0, 9, 0, 0, 0, 0, 1,   0,   0, 401};
        vecs[2] = '{5, 1, 5, 0, 0, 0, 0, 0, 288,  48, 401};
        vecs[3] = '{4, 3, 9, 7, 2, 1, 0, 0, 240, 176,   0};
        vecs[4] = '{2, 5, 7, 0, 0, 0, 1, 0, 112, 304, 401};
        vecs[5] = '{0, 4, 0, 0, 0, 0, 0, 0,   0, 240, 401};

        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        rstn = 1;

        foreach (vecs[i]) run_window(vecs[i]);

        // Randomized windows; expected coordinates from the window rules.
        for (int n = 0; n < 4; n++) begin
            v.tx = $urandom_range(2, 20);
            mode = $urandom_range(0, 2);
            v.cx = (mode == 0) ? 0 : (mode == 1) ? v.tx : $urandom_range(1, v.tx - 1);
            v.cy = $urandom_range(0, 30);
            v.ack_dly = $urandom_range(0, 3);
            v.gap = $urandom_range(0, 2);
            v.spur = 1'($urandom_range(0, 1));
            v.restart = 0; v.a5 = 0;
            v.ex = (v.cx == 0) ? 0 : (v.cx == v.tx) ? v.cx * 64 - 32 : v.cx * 64 - 16;
            v.ey = (v.cy == 0) ? 0 : v.cy * 64 - 16;
            v.ebusy = (v.ack_dly == 0 && v.gap == 0) ? 401 : 0;
            run_window(v);
        end

        // Abort with reset while receiving row 40, then restart cleanly.
        begin_window(vecs[0]);
        for (int c = 0; c < 2000 && exp_row < 40; c++) begin
            @(negedge clk); #1;
        end
        chk("reached_row40", exp_row, 40);
        repeat (3) @(negedge clk);
        #1;
        chk("abort_in_row40_y", rd_y, 112 + 40);
        chk_en = 0; rstn = 0; d0 = done_cnt;
        @(negedge clk); #1;
        check_zero("abort");
        @(negedge clk); #1;
        rstn = 1;
        repeat (20) @(negedge clk);
        #1;
        chk("no_done_after_abort", done_cnt, d0);
        chk("idle_after_abort", busy, 0);
        run_window(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
